// File: rtl/muldiv_issue.sv
// muldiv_issue: RV32M front end for the shared iterative multiply/divide core.
// Decodes funct3, extends operands to XLEN+1 bits, launches the core, resolves
// divide-by-zero and signed overflow locally, and stalls the pipeline until the
// selected result half is ready.
// Optional feature: define MULDIV_FUSE_CACHE_EN to reuse the previous core result
// when a new op has the same core_div and extended operands (MULH->MUL, DIV->REM).
module muldiv_issue #(
  parameter int XLEN     = 32,
  parameter int CORE_TMO = 80
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_req,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_stall,
  output logic [XLEN-1:0] o_result,
  output logic            o_result_valid,
  output logic            o_core_start,
  output logic            o_core_div,
  output logic [XLEN:0]   o_core_opA,
  output logic [XLEN:0]   o_core_opB,
  output logic            o_core_stall,
  input  logic            i_core_ready,
  input  logic [XLEN:0]   i_core_hi,
  input  logic [XLEN:0]   i_core_lo
);

  localparam int WDW = $clog2(CORE_TMO) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(CORE_TMO - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_funct3;
  logic            r_coreDiv;
  logic [XLEN:0]   r_opA;
  logic [XLEN:0]   r_opB;
  logic [XLEN-1:0] r_result;
  logic [WDW-1:0]  r_wdCnt;

  logic            w_isDiv;
  logic            w_signA;
  logic            w_signB;
  logic [XLEN:0]   w_extA;
  logic [XLEN:0]   w_extB;
  logic            w_divZero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_specialResult;
  logic            w_cacheHit;
  logic [XLEN-1:0] w_cacheResult;
  logic            w_loadOps;
  logic            w_loadResult;
  logic [XLEN-1:0] w_resultNext;
  logic            w_wdClear;
  logic            w_unusedBits;

  // MUL takes the low word; other multiplies the high word; DIV* quotient, REM* remainder
  function automatic logic [XLEN-1:0] selectHalf(input logic [2:0] f3,
                                                 input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo);
    if (f3 == 3'd0)   return lo;
    else if (!f3[2])  return hi;
    else if (f3[1])   return hi;
    else              return lo;
  endfunction

  // Operand decode: signed rs1 for MUL/MULH/MULHSU/DIV/REM, signed rs2 for MUL/MULH/DIV/REM
  always_comb begin
    w_isDiv   = i_funct3[2];
    w_signA   = i_funct3[2] ? ~i_funct3[0] : (i_funct3 != 3'd3);
    w_signB   = i_funct3[2] ? ~i_funct3[0] : ~i_funct3[1];
    w_extA    = {w_signA & i_rs1[XLEN-1], i_rs1};
    w_extB    = {w_signB & i_rs2[XLEN-1], i_rs2};
    w_divZero = w_isDiv & (i_rs2 == '0);
    w_ovf     = w_isDiv & ~i_funct3[0] & (i_rs1 == MIN_NEG) & (i_rs2 == '1);
    w_special = w_divZero | w_ovf;
    if (i_funct3[1]) w_specialResult = w_divZero ? i_rs1 : '0;
    else             w_specialResult = w_divZero ? '1 : MIN_NEG;
  end

  // The top bit of each core half only carries sign for the core's own use
  assign w_unusedBits = ^{i_core_hi[XLEN], i_core_lo[XLEN]};

`ifdef MULDIV_FUSE_CACHE_EN
  logic            r_cacheValid;
  logic            r_cacheDiv;
  logic [XLEN:0]   r_cacheA;
  logic [XLEN:0]   r_cacheB;
  logic [XLEN-1:0] r_cacheHi;
  logic [XLEN-1:0] r_cacheLo;

  assign w_cacheHit = r_cacheValid & ~w_special & (r_cacheDiv == w_isDiv) &
                      (r_cacheA == w_extA) & (r_cacheB == w_extB);
  assign w_cacheResult = selectHalf(i_funct3, r_cacheHi, r_cacheLo);

  // Remember the last core result; drop it on reset, watchdog expiry or a special-case op
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cacheValid <= 1'b0;
      r_cacheDiv   <= 1'b0;
      r_cacheA     <= '0;
      r_cacheB     <= '0;
      r_cacheHi    <= '0;
      r_cacheLo    <= '0;
    end else if (r_state == S_WAIT && i_core_ready) begin
      r_cacheValid <= 1'b1;
      r_cacheDiv   <= r_coreDiv;
      r_cacheA     <= r_opA;
      r_cacheB     <= r_opB;
      r_cacheHi    <= i_core_hi[XLEN-1:0];
      r_cacheLo    <= i_core_lo[XLEN-1:0];
    end else if ((r_state == S_WAIT && r_wdCnt == WD_LAST) ||
                 (r_state == S_IDLE && i_req && w_special)) begin
      r_cacheValid <= 1'b0;
    end
  end
`else
  assign w_cacheHit    = 1'b0;
  assign w_cacheResult = '0;
`endif

  // Next-state and load controls for the issue FSM
  always_comb begin
    w_next       = r_state;
    w_loadOps    = 1'b0;
    w_loadResult = 1'b0;
    w_resultNext = '0;
    w_wdClear    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_loadOps = 1'b1;
          if (w_special) begin
            w_next       = S_DONE;
            w_loadResult = 1'b1;
            w_resultNext = w_specialResult;
          end else if (w_cacheHit) begin
            w_next       = S_DONE;
            w_loadResult = 1'b1;
            w_resultNext = w_cacheResult;
          end else begin
            w_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_next    = S_WAIT;
        w_wdClear = 1'b1;
      end
      S_WAIT: begin
        if (i_core_ready) begin
          w_next       = S_DONE;
          w_loadResult = 1'b1;
          w_resultNext = selectHalf(r_funct3, i_core_hi[XLEN-1:0], i_core_lo[XLEN-1:0]);
        end else if (r_wdCnt == WD_LAST) begin
          w_next       = S_DONE;
          w_loadResult = 1'b1;
          w_resultNext = '0;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any op in flight
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Latched operands, result register and watchdog counter
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_funct3  <= '0;
      r_coreDiv <= 1'b0;
      r_opA     <= '0;
      r_opB     <= '0;
      r_result  <= '0;
      r_wdCnt   <= '0;
    end else begin
      if (w_loadOps) begin
        r_funct3  <= i_funct3;
        r_coreDiv <= w_isDiv;
        r_opA     <= w_extA;
        r_opB     <= w_extB;
      end
      if (w_loadResult) r_result <= w_resultNext;
      if (w_wdClear)              r_wdCnt <= '0;
      else if (r_state == S_WAIT) r_wdCnt <= r_wdCnt + WDW'(1);
    end
  end

  assign o_result_valid = (r_state == S_DONE);
  assign o_stall        = i_req & ~o_result_valid;
  assign o_core_start   = (r_state == S_ISSUE);
  assign o_core_stall   = (r_state == S_WAIT) & ~i_core_ready;
  assign o_core_div     = r_coreDiv;
  assign o_core_opA     = r_opA;
  assign o_core_opB     = r_opB;
  assign o_result       = r_result;

endmodule
